// File: rtl/key_scan.sv
//==============================================================================
// Module   : key_scan
// Purpose  : Four-key synchroniser and debouncer that turns debounced press
//            (and, with KEY_RELEASE_EVT_EN defined, release) edges into
//            encoded events on a valid/ready handshake.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module key_scan #(
   parameter int DB_CNT = 50000,
   parameter int CNT_W  = 16
) (
   input  logic       iclk,
   input  logic       rst,
   input  logic [3:0] keys_n,
   output logic [3:0] key_state,
   output logic       evt_valid,
   output logic [1:0] evt_code,
   output logic       evt_press,
   input  logic       evt_ready,
   output logic       evt_drop
);

   localparam logic [CNT_W-1:0] c_db_max = CNT_W'(DB_CNT - 1);

   logic [3:0]       r_sync1;
   logic [3:0]       r_sync2;
   logic [3:0]       w_s;
   logic [CNT_W-1:0] r_cnt [4];
   logic [3:0]       r_key_state;
   logic [3:0]       w_edge;
   logic [3:0]       w_rise;
   logic [3:0]       r_pend_p;
   logic [3:0]       w_clr_p;
   logic [3:0]       w_drop_p;
   logic             w_free;
   logic             w_any;
   logic [1:0]       w_code;
   logic             w_press;
   logic             r_valid;
   logic [1:0]       r_code;
   logic             r_press;
   logic             r_drop;
`ifdef KEY_RELEASE_EVT_EN
   logic [3:0]       w_fall;
   logic [3:0]       r_pend_r;
   logic [3:0]       w_clr_r;
   logic [3:0]       w_drop_r;
`endif

   always_ff @(posedge iclk or posedge rst) begin
      if (rst) begin
         r_sync1 <= 4'hF;
         r_sync2 <= 4'hF;
      end else begin
         r_sync1 <= keys_n;
         r_sync2 <= r_sync1;
      end
   end

   assign w_s = ~r_sync2;

   always_ff @(posedge iclk or posedge rst) begin
      if (rst) begin
         r_key_state <= 4'h0;
         for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (w_s[i] == r_key_state[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == c_db_max) begin
               r_cnt[i]       <= '0;
               r_key_state[i] <= w_s[i];
            end else begin
               r_cnt[i] <= r_cnt[i] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      w_edge = 4'h0;
      for (int i = 0; i < 4; i++)
         w_edge[i] = (w_s[i] != r_key_state[i]) && (r_cnt[i] == c_db_max);
   end

   assign w_rise = w_edge & w_s;
   assign w_free = !r_valid || evt_ready;

   // Scan from the top so the lowest pending index ends up selected.
   always_comb begin
      w_any   = 1'b0;
      w_code  = 2'd0;
      w_press = 1'b1;
      w_clr_p = 4'h0;
      for (int i = 3; i >= 0; i--) begin
`ifdef KEY_RELEASE_EVT_EN
         if (r_pend_p[i] || r_pend_r[i]) begin
            w_any   = 1'b1;
            w_code  = 2'(i);
            w_press = r_pend_p[i];
         end
`else
         if (r_pend_p[i]) begin
            w_any   = 1'b1;
            w_code  = 2'(i);
            w_press = 1'b1;
         end
`endif
      end
      if (w_free && w_any && w_press) w_clr_p[w_code] = 1'b1;
   end

   // A fresh edge landing on a bit being loaded this cycle is not a drop.
   assign w_drop_p = w_rise & r_pend_p & ~w_clr_p;

`ifdef KEY_RELEASE_EVT_EN
   assign w_fall = w_edge & ~w_s;

   always_comb begin
      w_clr_r = 4'h0;
      if (w_free && w_any && !w_press) w_clr_r[w_code] = 1'b1;
   end

   assign w_drop_r = w_fall & r_pend_r & ~w_clr_r;

   always_ff @(posedge iclk or posedge rst) begin
      if (rst) r_pend_r <= 4'h0;
      else     r_pend_r <= (r_pend_r & ~w_clr_r) | w_fall;
   end
`endif

   always_ff @(posedge iclk or posedge rst) begin
      if (rst) begin
         r_pend_p <= 4'h0;
         r_drop   <= 1'b0;
      end else begin
         r_pend_p <= (r_pend_p & ~w_clr_p) | w_rise;
`ifdef KEY_RELEASE_EVT_EN
         r_drop   <= |(w_drop_p | w_drop_r);
`else
         r_drop   <= |w_drop_p;
`endif
      end
   end

   always_ff @(posedge iclk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_code  <= 2'd0;
         r_press <= 1'b0;
      end else if (w_free) begin
         r_valid <= w_any;
         if (w_any) begin
            r_code  <= w_code;
            r_press <= w_press;
         end
      end
   end

   assign key_state = r_key_state;
   assign evt_valid = r_valid;
   assign evt_code  = r_code;
   assign evt_press = r_press;
   assign evt_drop  = r_drop;

endmodule

`default_nettype wire

// File: tb/tb_key_scan.sv
//==============================================================================
// Module   : tb_key_scan
// Purpose  : Scoreboard bench for key_scan with DB_CNT=4; expected events are
//            queued by the stimulus and popped by a handshake monitor.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_key_scan;

   localparam int DB = 4;

   logic       iclk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] keys_n = 4'hF;
   logic       evt_ready = 1'b0;
   logic [3:0] key_state;
   logic       evt_valid;
   logic [1:0] evt_code;
   logic       evt_press;
   logic       evt_drop;

   int checks = 0;
   int failures = 0;
   int drops = 0;
   logic [2:0] exp_q [$];
   logic [2:0] exp_e;
   logic       stall = 1'b0;
   logic [2:0] stall_v = 3'd0;

   key_scan #(.DB_CNT(DB), .CNT_W(16)) dut (
      .iclk      (iclk),
      .rst       (rst),
      .keys_n    (keys_n),
      .key_state (key_state),
      .evt_valid (evt_valid),
      .evt_code  (evt_code),
      .evt_press (evt_press),
      .evt_ready (evt_ready),
      .evt_drop  (evt_drop)
   );

   always #5 iclk = ~iclk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge iclk);
      #1;
   endtask

   // Monitor: pops the scoreboard on every handshake, checks hold under stall.
   always @(negedge iclk) begin
      if (rst) begin
         stall = 1'b0;
      end else begin
         if (evt_drop) drops++;
         if (stall) check("hold_stable", {evt_valid, evt_code, evt_press}, {1'b1, stall_v});
         if (evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_evt actual=%0h expected=none at %0t",
                        {evt_code, evt_press}, $time);
            end else begin
               exp_e = exp_q.pop_front();
               check("evt_code_press", {evt_code, evt_press}, exp_e);
            end
         end
         stall   = evt_valid && !evt_ready;
         stall_v = {evt_code, evt_press};
      end
   end

   initial begin
      // Reset state
      tick(3);
      check("reset_outputs", {key_state, evt_valid, evt_code, evt_press, evt_drop}, 0);
      rst = 1'b0;
      evt_ready = 1'b1;
      tick(10);
      check("post_reset_idle", {key_state, evt_valid}, 0);

      // Single press of key 0
      exp_q.push_back({2'd0, 1'b1});
      keys_n = 4'b1110;
      tick(5);
      check("press_not_yet", key_state, 4'b0000);
      tick(1);
      check("press_state", key_state, 4'b0001);
      check("press_valid_late", evt_valid, 1'b0);
      tick(1);
      check("press_valid", {evt_valid, evt_code, evt_press}, {1'b1, 2'd0, 1'b1});
      tick(1);
      check("press_one_cycle", evt_valid, 1'b0);
`ifdef KEY_RELEASE_EVT_EN
      exp_q.push_back({2'd0, 1'b0});
`endif
      keys_n = 4'hF;
      tick(10);
      check("release_state", key_state, 4'b0000);

      // Glitch rejection on key 2
      keys_n = 4'b1011;
      tick(3);
      keys_n = 4'hF;
      tick(10);
      check("glitch_state", key_state, 4'b0000);
      check("glitch_valid", evt_valid, 1'b0);

      // Keys 3 and 1 together under backpressure
      evt_ready = 1'b0;
      exp_q.push_back({2'd1, 1'b1});
      exp_q.push_back({2'd3, 1'b1});
      keys_n = 4'b0101;
      tick(12);
      check("bp_state", key_state, 4'b1010);
      check("bp_first", {evt_valid, evt_code}, {1'b1, 2'd1});
      evt_ready = 1'b1;
      tick(1);
      check("bp_second", {evt_valid, evt_code}, {1'b1, 2'd3});
      tick(1);
      check("bp_empty", evt_valid, 1'b0);
`ifdef KEY_RELEASE_EVT_EN
      exp_q.push_back({2'd1, 1'b0});
      exp_q.push_back({2'd3, 1'b0});
`endif
      keys_n = 4'hF;
      tick(12);

      // Drop: key 3 occupies the slot, key 0 pressed, released, re-pressed
      evt_ready = 1'b0;
      drops = 0;
      exp_q.push_back({2'd3, 1'b1});
      keys_n = 4'b0111;
      tick(8);
      exp_q.push_back({2'd0, 1'b1});
      keys_n = 4'b0110;
      tick(8);
`ifdef KEY_RELEASE_EVT_EN
      exp_q.push_back({2'd0, 1'b0});
`endif
      keys_n = 4'b0111;
      tick(8);
      keys_n = 4'b0110;
      tick(8);
      check("drop_count", drops, 1);
      check("drop_state", key_state, 4'b1001);
      evt_ready = 1'b1;
      tick(6);
      check("drop_drained", exp_q.size(), 0);
`ifdef KEY_RELEASE_EVT_EN
      exp_q.push_back({2'd0, 1'b0});
      exp_q.push_back({2'd3, 1'b0});
`endif
      keys_n = 4'hF;
      tick(12);
      check("drop_release_state", key_state, 4'b0000);

`ifdef KEY_RELEASE_EVT_EN
      // Press then release of key 2
      exp_q.push_back({2'd2, 1'b1});
      exp_q.push_back({2'd2, 1'b0});
      keys_n = 4'b1011;
      tick(10);
      keys_n = 4'hF;
      tick(10);
      check("rel_drained", exp_q.size(), 0);
`endif

      // Asynchronous reset while an event is held
      evt_ready = 1'b0;
      exp_q.push_back({2'd2, 1'b1});
      keys_n = 4'b1011;
      tick(8);
      check("pre_reset_valid", {evt_valid, evt_code}, {1'b1, 2'd2});
      #2 rst = 1'b1;
      #1 check("async_reset", {key_state, evt_valid, evt_code, evt_press, evt_drop}, 0);
      exp_q.delete();
      keys_n = 4'hF;
      tick(2);
      rst = 1'b0;
      evt_ready = 1'b1;
      tick(12);
      check("after_reset_idle", {key_state, evt_valid}, 0);

      check("queue_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
